// File: rtl/vga_sync_porch.sv
// vga_sync_porch: locks to upstream active-area flags, regenerates col/row, drives 640x480@60 syncs
// and blanked, delay-aligned RGB. Defining VGA_TEST_PATTERN_EN adds I_Pattern_Sel colour bars.
`timescale 1ns/1ps
module vga_sync_porch #(
  parameter int ACTIVE_COLS = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int TOTAL_COLS  = 800,
  parameter int ACTIVE_ROWS = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int TOTAL_ROWS  = 525,
  parameter int VIDEO_DELAY = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       I_HSync,
  input  logic       I_VSync,
  input  logic [2:0] I_Red,
  input  logic [2:0] I_Grn,
  input  logic [2:0] I_Blu,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       I_Pattern_Sel,
`endif
  output logic       O_HSync,
  output logic       O_VSync,
  output logic [2:0] O_Red,
  output logic [2:0] O_Grn,
  output logic [2:0] O_Blu,
  output logic [9:0] O_Col,
  output logic [9:0] O_Row,
  output logic       O_Locked,
  output logic       O_Sync_Err
);

  // state       | meaning
  // ST_UNLOCKED | waiting for frame_start; syncs idle, RGB blanked
  // ST_LOCKED   | counters trusted; syncs and video driven
  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  localparam logic [9:0] C_COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] C_ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] C_ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] C_ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] C_HS_BEG   = 10'(ACTIVE_COLS + H_FRONT);
  localparam logic [9:0] C_HS_END   = 10'(ACTIVE_COLS + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] C_VS_BEG   = 10'(ACTIVE_ROWS + V_FRONT);
  localparam logic [9:0] C_VS_END   = 10'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

  state_t     r_state;
  logic       r_hs_prev, r_vs_prev;
  logic [9:0] r_col, r_row;
  logic       r_sync_err;
  logic       r_hsync, r_vsync, r_locked;
  logic [8:0] r_rgb;
  logic [9:0] r_col_out, r_row_out;

  logic       w_frame_start, w_line_start;
  logic       w_locked, w_hs_act, w_vs_act, w_visible;
  logic [8:0] w_pix_in, w_pix_dly, w_pix_src;

  assign w_frame_start = I_VSync & ~r_vs_prev;
  // a coincident line start is absorbed by the frame start
  assign w_line_start  = I_HSync & ~r_hs_prev & ~w_frame_start;
  assign w_pix_in      = {I_Red, I_Grn, I_Blu};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_hs_prev <= I_HSync;
      r_vs_prev <= I_VSync;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_line_start) begin
      r_col <= '0;
      r_row <= (r_row == C_ROW_LAST) ? 10'd0 : r_row + 10'd1;
    end else begin
      r_col <= (r_col == C_COL_LAST) ? 10'd0 : r_col + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_UNLOCKED;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      case (r_state)
        ST_UNLOCKED: begin
          if (w_frame_start) r_state <= ST_LOCKED;
        end
        ST_LOCKED: begin
          if (w_frame_start) begin
            if (r_row != C_ROW_LAST || r_col != C_COL_LAST) r_sync_err <= 1'b1;
          end else if (w_line_start && r_col != C_COL_LAST) begin
            r_sync_err <= 1'b1;
            r_state    <= ST_UNLOCKED;
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

  generate
    if (VIDEO_DELAY <= 1) begin : g_no_dly
      assign w_pix_dly = w_pix_in;
    end else begin : g_dly
      logic [8:0] r_dly [VIDEO_DELAY-1];
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < VIDEO_DELAY - 1; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_pix_in;
          for (int i = 1; i < VIDEO_DELAY - 1; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_pix_dly = r_dly[VIDEO_DELAY-2];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = ACTIVE_COLS / 8;
  logic [2:0] w_bar_idx;
  logic [8:0] w_bar_rgb;

  always_comb begin
    w_bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (r_col >= 10'(b * BAR_W)) w_bar_idx = 3'(b);
    end
  end

  assign w_bar_rgb = {{3{w_bar_idx[2]}}, {3{w_bar_idx[1]}}, {3{w_bar_idx[0]}}};
  assign w_pix_src = I_Pattern_Sel ? w_bar_rgb : w_pix_dly;
`else
  assign w_pix_src = w_pix_dly;
`endif

  assign w_locked  = (r_state == ST_LOCKED);
  assign w_hs_act  = w_locked && (r_col >= C_HS_BEG) && (r_col <= C_HS_END);
  assign w_vs_act  = w_locked && (r_row >= C_VS_BEG) && (r_row <= C_VS_END);
  assign w_visible = w_locked && (r_col < C_ACT_COLS) && (r_row < C_ACT_ROWS);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_rgb     <= '0;
      r_col_out <= '0;
      r_row_out <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_hsync   <= ~w_hs_act;
      r_vsync   <= ~w_vs_act;
      r_rgb     <= w_visible ? w_pix_src : 9'd0;
      r_col_out <= r_col;
      r_row_out <= r_row;
      r_locked  <= w_locked;
    end
  end

  assign O_HSync    = r_hsync;
  assign O_VSync    = r_vsync;
  assign O_Red      = r_rgb[8:6];
  assign O_Grn      = r_rgb[5:3];
  assign O_Blu      = r_rgb[2:0];
  assign O_Col      = r_col_out;
  assign O_Row      = r_row_out;
  assign O_Locked   = r_locked;
  assign O_Sync_Err = r_sync_err;

endmodule

// File: tb/tb_vga_sync_porch.sv
// tb_vga_sync_porch: drives an upstream active-flag generator with random pixels and compares
// every output cycle against a position/latency reference model, plus directed timing checks.
`timescale 1ns/1ps
module tb_vga_sync_porch;
  localparam int AC = 64, HF = 4, HS = 8, TC = 80;
  localparam int AR = 24, VF = 2, VS = 2, TR = 30;
  localparam int VD = 2;
  localparam int BW = AC / 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       I_HSync = 1'b0, I_VSync = 1'b0;
  logic [2:0] I_Red = '0, I_Grn = '0, I_Blu = '0;
  logic       O_HSync, O_VSync, O_Locked, O_Sync_Err;
  logic [2:0] O_Red, O_Grn, O_Blu;
  logic [9:0] O_Col, O_Row;
`ifdef VGA_TEST_PATTERN_EN
  logic       I_Pattern_Sel = 1'b0;
`endif

  vga_sync_porch #(
    .ACTIVE_COLS(AC), .H_FRONT(HF), .H_SYNC(HS), .TOTAL_COLS(TC),
    .ACTIVE_ROWS(AR), .V_FRONT(VF), .V_SYNC(VS), .TOTAL_ROWS(TR),
    .VIDEO_DELAY(VD)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_HSync(I_HSync), .I_VSync(I_VSync),
    .I_Red(I_Red), .I_Grn(I_Grn), .I_Blu(I_Blu),
`ifdef VGA_TEST_PATTERN_EN
    .I_Pattern_Sel(I_Pattern_Sel),
`endif
    .O_HSync(O_HSync), .O_VSync(O_VSync),
    .O_Red(O_Red), .O_Grn(O_Grn), .O_Blu(O_Blu),
    .O_Col(O_Col), .O_Row(O_Row),
    .O_Locked(O_Locked), .O_Sync_Err(O_Sync_Err)
  );

  always #20 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // upstream generator position (next value to drive)
  int         g_col = 10, g_row = AR + 3;
  bit         fixed_pix = 0;
  logic [8:0] fixed_val = '0;
  bit         drv_pv = 0, drv_fs = 0;

  // reference model: position as seen by the block, lock flag, pixel history
  bit         m_ph, m_pv, m_lock, m_pat;
  int         m_col, m_row;
  logic [8:0] m_hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] bar_rgb(input int col);
    logic [2:0] idx;
    idx = 3'(col / BW);
    return {{3{idx[2]}}, {3{idx[1]}}, {3{idx[0]}}};
  endfunction

  task automatic model_clear();
    m_ph = 0; m_pv = 0; m_lock = 0; m_col = 0; m_row = 0;
    m_hist = {};
    repeat (VD) m_hist.push_front(9'd0);
  endtask

  task automatic drive_gen(output bit h, output bit v, output logic [8:0] pix);
    pix = fixed_pix ? fixed_val : 9'($urandom_range(0, 511));
    h = (g_col < AC);
    v = (g_row < AR);
    I_HSync = h;
    I_VSync = v;
    {I_Red, I_Grn, I_Blu} = pix;
    drv_fs = v && !drv_pv;
    drv_pv = v;
    g_col++;
    if (g_col == TC) begin
      g_col = 0;
      g_row = (g_row + 1) % TR;
    end
  endtask

  task automatic tick();
    bit h, v, fs, ls, err, vis;
    logic [8:0]  pix, rgb;
    logic [32:0] exp_v, obs_v;
    drive_gen(h, v, pix);
    m_hist.push_front(pix);
    void'(m_hist.pop_back());
    fs  = v && !m_pv;
    ls  = h && !m_ph && !fs;
    vis = m_lock && (m_col < AC) && (m_row < AR);
    rgb = 9'd0;
    if (vis) rgb = m_pat ? bar_rgb(m_col) : m_hist[VD-1];
    err = m_lock && ((fs && (m_row != TR-1 || m_col != TC-1)) || (ls && m_col != TC-1));
    exp_v = {!(m_lock && m_col >= AC+HF && m_col < AC+HF+HS),
             !(m_lock && m_row >= AR+VF && m_row < AR+VF+VS),
             rgb, 10'(m_col), 10'(m_row), m_lock, err};
    if (fs) begin
      m_col = 0; m_row = 0; m_lock = 1;
    end else if (ls) begin
      if (err) m_lock = 0;
      m_col = 0;
      m_row = (m_row + 1) % TR;
    end else begin
      m_col = (m_col + 1) % TC;
    end
    m_ph = h;
    m_pv = v;
    @(posedge CLK);
    #1;
    obs_v = {O_HSync, O_VSync, O_Red, O_Grn, O_Blu, O_Col, O_Row, O_Locked, O_Sync_Err};
    chk("cycle", obs_v, exp_v);
  endtask

  task automatic reset_dut(input int n);
    bit h, v;
    logic [8:0] pix;
    #3 RST_N = 1'b0;
    #1;
    chk("reset_async", {O_HSync, O_VSync, O_Red, O_Grn, O_Blu, O_Col, O_Row, O_Locked, O_Sync_Err},
        {2'b11, 31'd0});
    model_clear();
    repeat (n) begin
      @(posedge CLK);
      #1;
      drive_gen(h, v, pix);
      chk("reset_hold", {O_HSync, O_VSync, O_Red, O_Grn, O_Blu, O_Col, O_Row, O_Locked, O_Sync_Err},
          {2'b11, 31'd0});
    end
    RST_N = 1'b1;
  endtask

  task automatic wait_pos(input int col, input int row, input string tag);
    bit found = 0;
    for (int k = 0; k < 2*TC*TR && !found; k++) begin
      tick();
      found = (O_Col == 10'(col)) && (O_Row == 10'(row));
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_gen(input int row, input int col, input string tag);
    bit found = 0;
    for (int k = 0; k < 2*TC*TR && !found; k++) begin
      if (g_row == row && g_col == col) found = 1;
      else tick();
    end
    chk(tag, found, 1);
  endtask

  task automatic run_until_frame(input string tag);
    bit seen = 0;
    for (int k = 0; k < 2*TC*TR && !seen; k++) begin
      tick();
      seen = drv_fs;
    end
    chk({tag, "_wait"}, seen, 1);
    tick();
    chk({tag, "_col"}, O_Col, 0);
    chk({tag, "_row"}, O_Row, 0);
    chk({tag, "_locked"}, O_Locked, 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, viol, r, c;
    bit  found, seen;
    logic [8:0] c753;

    model_clear();
    m_pat = 0;
    reset_dut(3);
    run_until_frame("lock_first");

    // horizontal sync placement and width
    found = 0;
    for (int k = 0; k < 2*TC && !found; k++) begin
      tick();
      found = (O_HSync == 1'b0);
    end
    chk("hs_fall_seen", found, 1);
    chk("hs_start_col", O_Col, AC + HF);
    n = 0;
    for (int k = 0; k < 2*TC && O_HSync == 1'b0; k++) begin
      tick();
      n++;
    end
    chk("hs_width", n, HS);

    wait_pos(0, 1, "line_start_seen");
    n = 0;
    for (int k = 0; k < 2*TC; k++) begin
      tick();
      n++;
      if (O_Col == 10'd0) break;
    end
    chk("line_period", n, TC);

    // blanking with a constant pixel
    c753 = {3'd7, 3'd5, 3'd3};
    fixed_val = c753;
    fixed_pix = 1;
    wait_pos(AC - 1, 3, "blank_in_pos");
    chk("blank_in", {O_Red, O_Grn, O_Blu}, c753);
    tick();
    chk("blank_h", {O_Red, O_Grn, O_Blu}, 0);
    wait_pos(0, AR, "blank_v_pos");
    chk("blank_v", {O_Red, O_Grn, O_Blu}, 0);
    fixed_pix = 0;

    // vertical sync rows
    found = 0;
    for (int k = 0; k < 2*TC*TR && !found; k++) begin
      tick();
      found = (O_VSync == 1'b0);
    end
    chk("vs_fall_seen", found, 1);
    chk("vs_start_row", O_Row, AR + VF);
    chk("vs_start_col", O_Col, 0);
    n = 0;
    for (int k = 0; k < 2*TC*TR && O_VSync == 1'b0; k++) begin
      tick();
      n++;
    end
    chk("vs_width", n, VS * TC);

    wait_pos(0, 0, "frame_start_seen");
    n = 0;
    for (int k = 0; k < 2*TC*TR; k++) begin
      tick();
      n++;
      if (O_Col == 10'd0 && O_Row == 10'd0) break;
    end
    chk("frame_period", n, TC * TR);

    // reset in vertical blanking, relock on next frame
    wait_gen(AR + 1, 20, "rst_pos");
    reset_dut(3);
    chk("rst_unlocked", O_Locked, 0);
    run_until_frame("relock_rst");

    // short line while locked
    r = $urandom_range(2, AR - 2);
    c = $urandom_range(AC + 1, TC - 1);
    wait_gen(r, c, "sl_pos");
    g_col = 0;
    tick();
    chk("sl_err", O_Sync_Err, 1);
    tick();
    chk("sl_err_clear", O_Sync_Err, 0);
    chk("sl_unlock", O_Locked, 0);
    viol = 0;
    seen = 0;
    for (int k = 0; k < 2*TC*TR && !seen; k++) begin
      tick();
      seen = drv_fs;
      if (!seen && (O_HSync !== 1'b1 || O_VSync !== 1'b1 || O_Locked !== 1'b0)) viol++;
    end
    chk("sl_wait_frame", seen, 1);
    chk("sl_sync_idle", viol, 0);
    tick();
    chk("sl_relock", O_Locked, 1);

    // early frame while locked
    r = $urandom_range(2, AR - 2);
    wait_gen(r, AC + 2, "ef_pos");
    g_row = TR - 1;
    g_col = TC - 3;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = drv_fs;
    end
    chk("ef_wait", seen, 1);
    chk("ef_err", O_Sync_Err, 1);
    chk("ef_locked", O_Locked, 1);
    tick();
    chk("ef_row0", O_Row, 0);
    chk("ef_col0", O_Col, 0);
    chk("ef_still_locked", O_Locked, 1);

`ifdef VGA_TEST_PATTERN_EN
    I_Pattern_Sel = 1'b1;
    m_pat = 1;
    wait_pos(0, 2, "bar_pos");
    chk("bar0", {O_Red, O_Grn, O_Blu}, 9'h000);
    repeat (BW) tick();
    chk("bar1", {O_Red, O_Grn, O_Blu}, 9'h007);
    repeat (6 * BW) tick();
    chk("bar7_first", {O_Red, O_Grn, O_Blu}, 9'h1FF);
    repeat (BW - 1) tick();
    chk("bar7_last", {O_Red, O_Grn, O_Blu}, 9'h1FF);
    tick();
    chk("bar_blank", {O_Red, O_Grn, O_Blu}, 9'h000);
    I_Pattern_Sel = 1'b0;
    m_pat = 0;
`endif

    repeat (2 * TC) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_porch.md
Name: vga_sync_porch

Overview:
- Sits directly downstream of the raw sync/counter generator.
- Its inputs are two level flags, one per axis: high while the generator is in an active column/row, low while it is in the remainder of the line/frame.
- It locks to those flags, regenerates column/row counters, and produces standard 640x480@60 VGA sync pulses with front/back porch placement.
- It also blanks and delay-aligns the 3-bit-per-channel pixel data for the DAC/pin stage.

Parameters:
ACTIVE_COLS, 640, visible pixels per line
H_FRONT, 16, front porch columns after active region
H_SYNC, 96, HSync pulse width in columns
TOTAL_COLS, 800, columns per line (back porch = TOTAL_COLS-ACTIVE_COLS-H_FRONT-H_SYNC)
ACTIVE_ROWS, 480, visible lines per frame
V_FRONT, 10, front porch lines
V_SYNC, 2, VSync pulse width in lines
TOTAL_ROWS, 525, lines per frame
VIDEO_DELAY, 2, total cycles from I_Red/I_Grn/I_Blu to O_Red/O_Grn/O_Blu, including the output register; legal range 1..8

Ports:
CLK  in  1  pixel clock, 25 MHz
RST_N  in  1  asynchronous active-low reset
I_HSync  in  1  line-active flag from upstream generator
I_VSync  in  1  frame-active flag from upstream generator
I_Red  in  3  pixel red
I_Grn  in  3  pixel green
I_Blu  in  3  pixel blue
O_HSync  out  1  VGA HSync, active-low pulse
O_VSync  out  1  VGA VSync, active-low pulse
O_Red  out  3  blanked red
O_Grn  out  3  blanked green
O_Blu  out  3  blanked blue
O_Col  out  10  regenerated column, registered
O_Row  out  10  regenerated row, registered
O_Locked  out  1  high while timing is locked
O_Sync_Err  out  1  one-cycle pulse on timing mismatch

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: O_HSync=1, O_VSync=1, RGB=0, O_Col=0, O_Row=0, O_Locked=0, O_Sync_Err=0. Internal counters, edge registers and the delay line also clear to 0. Asserting RST_N low mid-frame returns the block to UNLOCKED immediately.
- Edge detect: a registered copy of each flag is kept. line_start = I_HSync & ~prev_HSync; frame_start = I_VSync & ~prev_VSync.
- Counters (col_cnt, row_cnt), evaluated in priority order:
  - frame_start: col_cnt<=0, row_cnt<=0.
  - else line_start: col_cnt<=0; row_cnt wraps TOTAL_ROWS-1 -> 0, otherwise increments.
  - else: col_cnt wraps TOTAL_COLS-1 -> 0, otherwise increments.
  - On a free-running col wrap without a line_start, row_cnt does not change.
- State machine:
  - UNLOCKED: outputs idle (syncs 1, RGB 0). frame_start -> LOCKED.
  - LOCKED, line_start with col_cnt != TOTAL_COLS-1: pulse O_Sync_Err, go to UNLOCKED.
  - LOCKED, frame_start with row_cnt != TOTAL_ROWS-1 or col_cnt != TOTAL_COLS-1: pulse O_Sync_Err, stay LOCKED, counters realign to 0.
  - Simultaneous line_start and frame_start: handled as frame_start only.
- Output timing: all outputs are registered from the current counter values. Latency from a flag rising to O_Col=0 is 2 cycles.
- O_HSync=0 when locked and col_cnt is in [ACTIVE_COLS+H_FRONT, ACTIVE_COLS+H_FRONT+H_SYNC-1], i.e. 656..751 at defaults.
- O_VSync=0 when locked and row_cnt is in [ACTIVE_ROWS+V_FRONT, ACTIVE_ROWS+V_FRONT+V_SYNC-1], i.e. 490..491.
- Video path: RGB passes through a (VIDEO_DELAY-1)-stage shift register, then the output register. The output register loads the delayed pixel when locked and col_cnt<ACTIVE_COLS and row_cnt<ACTIVE_ROWS; otherwise it loads 0.
- Alignment: with VIDEO_DELAY=2, the pixel presented in the same cycle as the first high I_HSync appears at O_Col=0.
- O_Locked is registered and follows the state.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input port I_Pattern_Sel (1 bit). When it is 1, the output register loads internal colour bars instead of delayed input: eight bars, each ACTIVE_COLS/8 columns wide, colour index = col_cnt/(ACTIVE_COLS/8), with R, G and B each = {3{index[2]}}, {3{index[1]}}, {3{index[0]}}. Blanking rules are unchanged.
- Undefined: port absent; pass-through only.

Test Plan:
- Reset mid-frame: drop RST_N for 3 cycles -> all outputs at reset values within the same cycle; O_Locked=0 until the next I_VSync rising edge; +2 cycles later O_Col=0, O_Row=0, O_Locked=1.
- Nominal frame from the upstream generator: HSync low exactly 96 cycles starting at O_Col=656; VSync low for rows 490-491 only; line period 800 cycles, frame period 420000 cycles.
- Blanking: I_Red=7, I_Grn=5, I_Blu=3 constant -> outputs 7/5/3 only for O_Col<640 and O_Row<480, 0 elsewhere and while unlocked.
- Short line: line_start injected at col_cnt=700 -> O_Sync_Err one-cycle pulse, O_Locked falls, syncs held 1 until the next frame_start relocks.
- Early frame: frame_start at row_cnt=300 -> O_Sync_Err pulse, O_Locked stays 1, O_Row=0 two cycles later.
- VGA_TEST_PATTERN_EN with I_Pattern_Sel=1 -> O_Col 0-79 gives RGB 0/0/0, O_Col 560-639 gives 7/7/7, O_Col 80 gives 0/0/7.
